// File: rtl/rs_issue_queue.sv
// rs_issue_queue: per-pipe reservation station.
// Holds dispatched uops and wakes their operands from writeback and
// speculative tag broadcasts. Each cycle it issues the oldest uop that is
// ready, and it schedules a latency-timed speculative wakeup for that uop's
// destination tag.
module rs_issue_queue #(
    parameter int RS_ENTRIES = 8,
    parameter int PREG_W     = 6,
    parameter int LAT_W      = 3,
    parameter int WB_PORTS   = 2,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,            // synchronous, active-low
    input  logic                            i_flush,
    // dispatch
    input  logic                            i_disp_valid,
    input  logic [PREG_W-1:0]               i_disp_dst_preg,
    input  logic [PREG_W-1:0]               i_disp_src1_preg,
    input  logic [PREG_W-1:0]               i_disp_src2_preg,
    input  logic                            i_disp_src1_rdy,
    input  logic                            i_disp_src2_rdy,
    input  logic [LAT_W-1:0]                i_disp_latency,
    input  logic [PAYLOAD_W-1:0]            i_disp_payload,
    output logic                            o_entry_free,
    output logic [$clog2(RS_ENTRIES)-1:0]   o_entry_index,
    output logic [$clog2(RS_ENTRIES):0]     o_occupancy,
    // writeback tag broadcast
    input  logic [WB_PORTS-1:0]             i_wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]      i_wb_preg,
    // issue
    output logic                            o_issue_valid,
    input  logic                            i_issue_ready,
    output logic [PREG_W-1:0]               o_issue_dst_preg,
    output logic [PREG_W-1:0]               o_issue_src1_preg,
    output logic [PREG_W-1:0]               o_issue_src2_preg,
    output logic [PAYLOAD_W-1:0]            o_issue_payload,
    // speculative wakeup broadcast
    output logic                            o_wake_out_valid,
    output logic [PREG_W-1:0]               o_wake_out_preg
);

    localparam int              IDX_W      = $clog2(RS_ENTRIES);
    localparam int              WAKE_SLOTS = (1 << LAT_W) - 1;
    localparam logic [LAT_W-1:0] LAT_NONE  = {LAT_W{1'b1}};

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] preg;
    } wake_slot_t;

    // True when tag matches any valid writeback port or the live speculative wakeup.
    function automatic logic tag_hit(
        input logic [PREG_W-1:0]          tag,
        input logic [WB_PORTS-1:0]        wb_v,
        input logic [WB_PORTS*PREG_W-1:0] wb_p,
        input wake_slot_t                 wo
    );
        logic hit;
        hit = wo.valid && (wo.preg == tag);
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_v[k] && (wb_p[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // A latency of zero is scheduled as one cycle.
    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? LAT_W'(1) : lat;
    endfunction

    // Entry state
    logic [RS_ENTRIES-1:0] r_valid;
    logic [RS_ENTRIES-1:0] r_src1_rdy;
    logic [RS_ENTRIES-1:0] r_src2_rdy;
    logic [PREG_W-1:0]     r_dst     [RS_ENTRIES];
    logic [PREG_W-1:0]     r_src1    [RS_ENTRIES];
    logic [PREG_W-1:0]     r_src2    [RS_ENTRIES];
    logic [LAT_W-1:0]      r_lat     [RS_ENTRIES];
    logic [PAYLOAD_W-1:0]  r_payload [RS_ENTRIES];
    // r_age[i][j] = 1 means entry i is older than entry j.
    logic [RS_ENTRIES-1:0] r_age     [RS_ENTRIES];

    // Wake shift register: slot 0 drives the broadcast this cycle.
    wake_slot_t            r_wake      [WAKE_SLOTS];
    wake_slot_t            w_wake_next [WAKE_SLOTS];

    logic                  w_entry_free;
    logic [IDX_W-1:0]      w_entry_index;
    logic [IDX_W:0]        w_occupancy;
    logic [RS_ENTRIES-1:0] w_elig;
    logic [RS_ENTRIES-1:0] w_sel_oh;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_any_elig;
    logic                  w_issue_fire;
    logic                  w_alloc;
    logic [RS_ENTRIES-1:0] w_hit1;
    logic [RS_ENTRIES-1:0] w_hit2;
    logic                  w_disp_hit1;
    logic                  w_disp_hit2;
    logic [LAT_W-1:0]      w_wake_pos;
    wake_slot_t            w_wake_out;

    assign w_wake_out = r_wake[0];

    // Lowest-index free entry and valid-entry count.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can form.
        w_entry_free  = 1'b0;
        w_entry_index = '0;
        w_occupancy   = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_entry_free  = 1'b1;
                w_entry_index = IDX_W'(i);
            end
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_occupancy = w_occupancy + {{IDX_W{1'b0}}, r_valid[i]};
        end
    end

    // Eligibility: both operands ready and the uop's wake slot is free.
    always_comb begin
        logic [LAT_W-1:0] lat_e;
        w_elig = '0;
        lat_e  = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            lat_e     = eff_lat(r_lat[i]);
            w_elig[i] = r_valid[i] && r_src1_rdy[i] && r_src2_rdy[i] &&
                        ((r_lat[i] == LAT_NONE) || !r_wake[lat_e].valid);
        end
    end

    // Oldest-eligible select: an entry wins if no other eligible entry is older.
    always_comb begin
        w_sel_oh  = '0;
        w_sel_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_sel_oh[i] = w_elig[i];
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (w_elig[j] && r_age[j][i]) w_sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (w_sel_oh[i]) w_sel_idx = IDX_W'(i);
        end
    end

    // Tag-match wakeups for resident entries and for the incoming uop.
    always_comb begin
        w_hit1 = '0;
        w_hit2 = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_hit1[i] = tag_hit(r_src1[i], i_wb_valid, i_wb_preg, w_wake_out);
            w_hit2[i] = tag_hit(r_src2[i], i_wb_valid, i_wb_preg, w_wake_out);
        end
        w_disp_hit1 = tag_hit(i_disp_src1_preg, i_wb_valid, i_wb_preg, w_wake_out);
        w_disp_hit2 = tag_hit(i_disp_src2_preg, i_wb_valid, i_wb_preg, w_wake_out);
    end

    assign w_any_elig   = |w_elig;
    assign w_issue_fire = o_issue_valid && i_issue_ready;
    assign w_alloc      = i_disp_valid && w_entry_free && !i_flush;
    assign w_wake_pos   = eff_lat(r_lat[w_sel_idx]) - LAT_W'(1);

    // Next wake-slot contents: shift toward slot 0, then insert the issuing uop's tag.
    always_comb begin
        for (int k = 0; k < WAKE_SLOTS - 1; k++) begin
            w_wake_next[k] = r_wake[k + 1];
        end
        w_wake_next[WAKE_SLOTS-1] = '0;
        if (w_issue_fire && (r_lat[w_sel_idx] != LAT_NONE)) begin
            w_wake_next[w_wake_pos] = '{valid: 1'b1, preg: r_dst[w_sel_idx]};
        end
    end

    // Control state: valid bits, ready bits and wake slots.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rst) begin
            r_valid    <= '0;
            r_src1_rdy <= '0;
            r_src2_rdy <= '0;
            for (int k = 0; k < WAKE_SLOTS; k++) r_wake[k] <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            for (int k = 0; k < WAKE_SLOTS; k++) r_wake[k] <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_hit1[i]) r_src1_rdy[i] <= 1'b1;
                if (w_hit2[i]) r_src2_rdy[i] <= 1'b1;
            end
            if (w_issue_fire) r_valid[w_sel_idx] <= 1'b0;
            // The allocated slot is always invalid, so it never collides with the issued slot.
            if (w_alloc) begin
                r_valid[w_entry_index]    <= 1'b1;
                r_src1_rdy[w_entry_index] <= i_disp_src1_rdy || w_disp_hit1;
                r_src2_rdy[w_entry_index] <= i_disp_src2_rdy || w_disp_hit2;
            end
            for (int k = 0; k < WAKE_SLOTS; k++) r_wake[k] <= w_wake_next[k];
        end
    end

    // Entry payload and age matrix, written on allocation.
    always_ff @(posedge i_clk) begin
        // NOTE: these arrays are not reset; a field is only read while its valid bit is set, and allocation rewrites it first.
        if (w_alloc) begin
            r_dst[w_entry_index]     <= i_disp_dst_preg;
            r_src1[w_entry_index]    <= i_disp_src1_preg;
            r_src2[w_entry_index]    <= i_disp_src2_preg;
            r_lat[w_entry_index]     <= i_disp_latency;
            r_payload[w_entry_index] <= i_disp_payload;
            r_age[w_entry_index]     <= '0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                r_age[j][w_entry_index] <= r_valid[j];
            end
        end
    end

    // Dispatch must never present a uop while the queue is full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            assert (!(i_disp_valid && !w_entry_free))
                else $error("rs_issue_queue: dispatch while no entry is free");
        end
    end

    assign o_entry_free      = w_entry_free;
    assign o_entry_index     = w_entry_index;
    assign o_occupancy       = w_occupancy;
    assign o_issue_valid     = w_any_elig && !i_flush;
    assign o_issue_dst_preg  = w_any_elig ? r_dst[w_sel_idx]     : '0;
    assign o_issue_src1_preg = w_any_elig ? r_src1[w_sel_idx]    : '0;
    assign o_issue_src2_preg = w_any_elig ? r_src2[w_sel_idx]    : '0;
    assign o_issue_payload   = w_any_elig ? r_payload[w_sel_idx] : '0;
    assign o_wake_out_valid  = w_wake_out.valid;
    assign o_wake_out_preg   = w_wake_out.preg;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed testbench for rs_issue_queue with hand-computed expectations.
module tb_rs_issue_queue;

    localparam int RS_ENTRIES = 8;
    localparam int PREG_W     = 6;
    localparam int LAT_W      = 3;
    localparam int WB_PORTS   = 2;
    localparam int PAYLOAD_W  = 64;
    localparam int IDX_W      = $clog2(RS_ENTRIES);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       disp_valid;
    logic [PREG_W-1:0]          disp_dst_preg, disp_src1_preg, disp_src2_preg;
    logic                       disp_src1_rdy, disp_src2_rdy;
    logic [LAT_W-1:0]           disp_latency;
    logic [PAYLOAD_W-1:0]       disp_payload;
    logic                       entry_free;
    logic [IDX_W-1:0]           entry_index;
    logic [IDX_W:0]             occupancy;
    logic [WB_PORTS-1:0]        wb_valid;
    logic [WB_PORTS*PREG_W-1:0] wb_preg;
    logic                       issue_valid;
    logic                       issue_ready;
    logic [PREG_W-1:0]          issue_dst_preg, issue_src1_preg, issue_src2_preg;
    logic [PAYLOAD_W-1:0]       issue_payload;
    logic                       wake_out_valid;
    logic [PREG_W-1:0]          wake_out_preg;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rs_issue_queue #(
        .RS_ENTRIES(RS_ENTRIES), .PREG_W(PREG_W), .LAT_W(LAT_W),
        .WB_PORTS(WB_PORTS), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_flush          (flush),
        .i_disp_valid     (disp_valid),
        .i_disp_dst_preg  (disp_dst_preg),
        .i_disp_src1_preg (disp_src1_preg),
        .i_disp_src2_preg (disp_src2_preg),
        .i_disp_src1_rdy  (disp_src1_rdy),
        .i_disp_src2_rdy  (disp_src2_rdy),
        .i_disp_latency   (disp_latency),
        .i_disp_payload   (disp_payload),
        .o_entry_free     (entry_free),
        .o_entry_index    (entry_index),
        .o_occupancy      (occupancy),
        .i_wb_valid       (wb_valid),
        .i_wb_preg        (wb_preg),
        .o_issue_valid    (issue_valid),
        .i_issue_ready    (issue_ready),
        .o_issue_dst_preg (issue_dst_preg),
        .o_issue_src1_preg(issue_src1_preg),
        .o_issue_src2_preg(issue_src2_preg),
        .o_issue_payload  (issue_payload),
        .o_wake_out_valid (wake_out_valid),
        .o_wake_out_preg  (wake_out_preg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [PREG_W-1:0] dst, input logic [PREG_W-1:0] s1,
                            input logic [PREG_W-1:0] s2, input logic r1, input logic r2,
                            input logic [LAT_W-1:0] lat, input logic [PAYLOAD_W-1:0] pl);
        disp_valid     = 1'b1;
        disp_dst_preg  = dst;
        disp_src1_preg = s1;
        disp_src2_preg = s2;
        disp_src1_rdy  = r1;
        disp_src2_rdy  = r2;
        disp_latency   = lat;
        disp_payload   = pl;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0;
        disp_dst_preg = '0; disp_src1_preg = '0; disp_src2_preg = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_latency = '0; disp_payload = '0;
        wb_valid = '0; wb_preg = '0; issue_ready = 1'b0;

        // ---- Reset held for two edges
        tick(); tick();
        chk("rst_entry_free", entry_free, 1);
        chk("rst_entry_index", entry_index, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_wake_valid", wake_out_valid, 0);
        chk("rst_wake_preg", wake_out_preg, 0);
        chk("rst_issue_payload", issue_payload, 0);
        chk("rst_issue_dst", issue_dst_preg, 0);
        rst = 1'b1;

        // ---- Fill all entries, then drain in dispatch order
        for (int i = 0; i < RS_ENTRIES; i++) begin
            set_disp(PREG_W'(16 + i), 6'd1, 6'd2, 1'b1, 1'b1, 3'd7, 64'(100 + i));
            #1;
            chk("fill_index", entry_index, i);
            tick();
        end
        disp_valid = 1'b0;
        #1;
        chk("full_occupancy", occupancy, 8);
        chk("full_entry_free", entry_free, 0);
        chk("full_issue_valid", issue_valid, 1);
        chk("full_oldest_payload", issue_payload, 100);
        issue_ready = 1'b1;
        for (int k = 0; k < RS_ENTRIES; k++) begin
            chk("drain_valid", issue_valid, 1);
            chk("drain_payload", issue_payload, 100 + k);
            chk("drain_dst", issue_dst_preg, 16 + k);
            tick();
            if (k == 0) begin
                chk("drain_free_after_first", entry_free, 1);
                chk("drain_occ_after_first", occupancy, 7);
                chk("drain_index_after_first", entry_index, 0);
            end
        end
        issue_ready = 1'b0;
        chk("drain_done_valid", issue_valid, 0);
        chk("drain_done_occ", occupancy, 0);

        // ---- Back-to-back via speculative wakeup (A: dst 5, L=1; B waits on 5)
        set_disp(6'd5, 6'd1, 6'd2, 1'b1, 1'b1, 3'd1, 64'hA);
        tick();
        set_disp(6'd6, 6'd5, 6'd3, 1'b0, 1'b1, 3'd7, 64'hB);
        tick();
        disp_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        chk("b2b_C_valid", issue_valid, 1);
        chk("b2b_C_payload", issue_payload, 64'hA);
        chk("b2b_C_wake", wake_out_valid, 0);
        tick();
        chk("b2b_C1_wake", wake_out_valid, 1);
        chk("b2b_C1_wake_preg", wake_out_preg, 5);
        chk("b2b_C1_valid", issue_valid, 0);
        tick();
        chk("b2b_C2_valid", issue_valid, 1);
        chk("b2b_C2_payload", issue_payload, 64'hB);
        chk("b2b_C2_src1", issue_src1_preg, 5);
        tick();
        chk("b2b_C3_valid", issue_valid, 0);
        chk("lat_none_no_wake", wake_out_valid, 0);
        chk("b2b_occ", occupancy, 0);

        // ---- Writeback wakeup on port 1
        set_disp(6'd10, 6'd9, 6'd4, 1'b0, 1'b1, 3'd7, 64'hC);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("wb_wait_valid", issue_valid, 0);
        wb_valid = 2'b10;
        wb_preg  = {6'd9, 6'd0};
        tick();
        wb_valid = '0;
        wb_preg  = '0;
        #1;
        chk("wb_woken_valid", issue_valid, 1);
        chk("wb_woken_payload", issue_payload, 64'hC);
        tick();
        chk("wb_issued", issue_valid, 0);

        // ---- Dispatch with same-cycle writeback of both sources
        set_disp(6'd11, 6'd9, 6'd12, 1'b0, 1'b0, 3'd7, 64'hD);
        wb_valid = 2'b11;
        wb_preg  = {6'd9, 6'd12};
        tick();
        disp_valid = 1'b0;
        wb_valid = '0;
        wb_preg  = '0;
        #1;
        chk("disp_wb_valid", issue_valid, 1);
        chk("disp_wb_payload", issue_payload, 64'hD);
        tick();
        chk("disp_wb_issued", issue_valid, 0);

        // ---- Tag present on an invalid port must not wake
        set_disp(6'd14, 6'd13, 6'd4, 1'b0, 1'b1, 3'd7, 64'hE);
        wb_valid = 2'b00;
        wb_preg  = {6'd13, 6'd13};
        tick();
        disp_valid = 1'b0;
        #1;
        chk("wb_invalid_no_wake", issue_valid, 0);
        wb_valid = 2'b01;
        tick();
        wb_valid = '0;
        wb_preg  = '0;
        #1;
        chk("wb_port0_woken", issue_valid, 1);
        chk("wb_port0_payload", issue_payload, 64'hE);
        tick();
        chk("wb_port0_issued", issue_valid, 0);

        // ---- Wake-slot collision: X (L=3) issues in C, Y (L=1) ready in C+2
        issue_ready = 1'b0;
        set_disp(6'd20, 6'd1, 6'd2, 1'b1, 1'b1, 3'd3, 64'h1);
        tick();
        set_disp(6'd21, 6'd30, 6'd2, 1'b0, 1'b1, 3'd1, 64'h2);
        tick();
        disp_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        chk("slot_C_valid", issue_valid, 1);
        chk("slot_C_payload", issue_payload, 64'h1);
        tick();
        chk("slot_C1_valid", issue_valid, 0);
        wb_valid = 2'b01;
        wb_preg  = {6'd0, 6'd30};
        tick();
        wb_valid = '0;
        wb_preg  = '0;
        #1;
        chk("slot_C2_suppressed", issue_valid, 0);
        chk("slot_C2_wake", wake_out_valid, 0);
        tick();
        chk("slot_C3_wake", wake_out_valid, 1);
        chk("slot_C3_wake_preg", wake_out_preg, 20);
        chk("slot_C3_valid", issue_valid, 1);
        chk("slot_C3_payload", issue_payload, 64'h2);
        tick();
        chk("slot_C4_wake", wake_out_valid, 1);
        chk("slot_C4_wake_preg", wake_out_preg, 21);
        chk("slot_C4_valid", issue_valid, 0);
        tick();
        chk("slot_C5_wake", wake_out_valid, 0);

        // ---- Latency 0 is scheduled as latency 1
        set_disp(6'd22, 6'd1, 6'd2, 1'b1, 1'b1, 3'd0, 64'h3);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("lat0_valid", issue_valid, 1);
        chk("lat0_payload", issue_payload, 64'h3);
        tick();
        chk("lat0_wake", wake_out_valid, 1);
        chk("lat0_wake_preg", wake_out_preg, 22);
        tick();
        chk("lat0_wake_done", wake_out_valid, 0);

        // ---- Flush with five valid entries and a pending wake
        issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_disp(PREG_W'(40 + i), 6'd1, 6'd2, 1'b1, 1'b1, 3'd4, 64'(200 + i));
            tick();
        end
        disp_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        chk("pre_flush_payload", issue_payload, 200);
        tick();
        issue_ready = 1'b0;
        #1;
        chk("pre_flush_occ", occupancy, 5);
        chk("pre_flush_wake", wake_out_valid, 0);
        flush = 1'b1;
        issue_ready = 1'b1;
        set_disp(6'd50, 6'd1, 6'd2, 1'b1, 1'b1, 3'd7, 64'hF);
        #1;
        chk("flush_issue_forced_low", issue_valid, 0);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        issue_ready = 1'b0;
        #1;
        chk("post_flush_occ", occupancy, 0);
        chk("post_flush_issue_valid", issue_valid, 0);
        chk("post_flush_wake", wake_out_valid, 0);
        chk("post_flush_free", entry_free, 1);
        chk("post_flush_index", entry_index, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_flush_no_late_wake", wake_out_valid, 0);
        end
        chk("post_flush_occ_final", occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_issue_queue.md
# rs_issue_queue

Per-pipe reservation station directly downstream of Dispatch: holds up to RS_ENTRIES dispatched uops, wakes their source operands on writeback and speculative tag broadcasts, selects the oldest ready uop each cycle, and issues it to its execution pipe. One instance exists per execution pipe. For ALU-class uops it also generates a latency-timed speculative wakeup so dependents can issue back-to-back.

## Interface
- RS_ENTRIES, 8, entry count (power of two, ≥2)
- PREG_W, 6, physical register tag width
- LAT_W, 3, latency field width; latency value all-ones = no speculative wakeup (LSU)
- WB_PORTS, 2, number of writeback tag broadcast ports
- PAYLOAD_W, 64, opaque uop payload width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  discard all entries and pending wakeups
- disp_valid  in  1  dispatch request
- disp_dst_preg / disp_src1_preg / disp_src2_preg  in  PREG_W each  tags
- disp_src1_rdy / disp_src2_rdy  in  1 each  operand already available
- disp_latency  in  LAT_W  execution latency
- disp_payload  in  PAYLOAD_W  opaque payload
- entry_free  out  1  at least one entry free
- entry_index  out  $clog2(RS_ENTRIES)  lowest-index free entry
- occupancy  out  $clog2(RS_ENTRIES)+1  valid entry count
- wb_valid  in  WB_PORTS  writeback broadcast valid per port
- wb_preg  in  WB_PORTS*PREG_W  writeback tags, port k at [k*PREG_W +: PREG_W]
- issue_valid  out  1  selected uop available
- issue_ready  in  1  pipe accepts
- issue_dst_preg / issue_src1_preg / issue_src2_preg  out  PREG_W each
- issue_payload  out  PAYLOAD_W
- wake_out_valid  out  1  speculative wakeup broadcast
- wake_out_preg  out  PREG_W  broadcast tag

## Operation
- Entry state: valid, src1_rdy, src2_rdy, tags, latency, payload; age matrix (RS_ENTRIES×RS_ENTRIES bits) for relative order.
- Allocate: disp_valid & entry_free & ~flush writes entry entry_index at the edge; new entry marked older-than-none, all other valid entries marked older than it. disp_valid while ~entry_free is ignored (Dispatch must not do this; assertion).
- Operand readiness on write = disp_srcN_rdy OR tag match on any wb_valid port OR match on wake_out in the same cycle.
- Wakeup: each cycle, every valid entry sets srcN_rdy when srcN_preg matches any valid wb_preg or wake_out_preg. Ready bits never clear except on dealloc.
- Select (combinational): eligible = valid & src1_rdy & src2_rdy & wake slot free (below); choose the oldest eligible by age matrix. issue_valid = any eligible & ~flush; issue_* driven from chosen entry (zeros when none).
- Issue: issue_valid & issue_ready at an edge clears that entry's valid. Freed entry is visible in entry_free/entry_index the following cycle (no same-cycle reuse).
- Speculative wakeup: wake shift register of 2^LAT_W−1 slots, each {valid, preg}. Issue handshake in cycle C with latency L (0 treated as 1, all-ones = none) places dst in the slot that drives wake_out in cycle C+L. An entry is ineligible if its target slot is already occupied (structural hazard); older ineligible entries do not block younger eligible ones.
- occupancy = popcount(valid).
- flush: at the edge, all valid bits and wake slots clear; same-cycle dispatch and issue are dropped; issue_valid forced 0 during flush.

## Timing
- Reset (rst=0 at edge): all entries invalid, wake slots empty; entry_free=1, entry_index=0, occupancy=0, issue_valid=0, wake_out_valid=0, wake_out_preg=0; issue_* tags/payload=0.
- Dispatch-to-issue minimum: allocated at edge T, issue_valid earliest in cycle T+1 (if ready).
- wb broadcast in cycle C → dependent eligible in cycle C+1; disp in cycle C with matching wb in C → eligible in C+1.
- Back-to-back: producer L=1 issued in C → wake_out in C+1 → consumer issue in C+2.
- Full: occupancy=RS_ENTRIES, entry_free=0; issuing one while full restores entry_free next cycle.
- entry_index wraps by priority, not pointer: always lowest free index.
- Stalled issue (issue_ready=0): selected uop may change if an older entry becomes ready; outputs need not hold.

## Test plan
- Reset with rst=0 two cycles → entry_free=1, entry_index=0, occupancy=0, issue_valid=0, wake_out_valid=0.
- Dispatch 8 uops with both rdy=1, issue_ready=0 → occupancy=8, entry_free=0; raise issue_ready → issues in dispatch order, one per cycle, entry_free=1 after first.
- Dispatch uop A (dst 5, L=1, rdy) then B (src1 5, not rdy) → A issues cycle C, wake_out_valid with preg 5 in C+1, B issues C+2.
- Dispatch B waiting on preg 9, drive wb_valid[1] with wb_preg[1]=9 in cycle C → B issue_valid in C+1; simultaneous dispatch+wb of tag 9 also ready next cycle.
- Issue X (L=3) in cycle C, Y (L=1) ready in C+2 → Y suppressed in C+2 (slot collision), issues C+3; latency all-ones uop produces no wake_out.
- Five valid entries with pending wakes, assert flush → next cycle occupancy=0, issue_valid=0, wake_out_valid=0; same-cycle disp_valid not allocated.
